// File: rtl/seq_alu.sv
// Sequential RISC-V integer ALU: single-cycle base ops, iterative (or optional
// single-cycle) multiply, iterative restoring divide, valid/ready handshake.
module seq_alu #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_flags
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic [2:0] funct3;
        logic       neg;
    } req_t;

    state_t          state, state_nxt;
    req_t            req;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] hi, lo, mcand;

    logic            accept, is_m, sub, a_sgn, b_sgn, neg, div_zero, div_ovf, last;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] b_eff, base_res, mag_a, mag_b, acc_res;
    logic [XLEN:0]   sum;
    logic [3:0]      base_flags;
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fprod;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign is_m      = (funct7 == 7'b0000001);
    assign sub       = funct7[5];
    assign sh        = op_b[SHW-1:0];
    assign last      = (cnt == SHW'(XLEN-1));

    // Operand signedness: divides are signed on even funct3, MULH/MULHSU sign op_a, MULH signs op_b
    always_comb begin
        a_sgn = op_a[XLEN-1] && (funct3[2] ? !funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010));
        b_sgn = op_b[XLEN-1] && (funct3[2] ? !funct3[0] : (funct3 == 3'b001));
        neg   = (funct3[2] && funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
        mag_a = a_sgn ? -op_a : op_a;
        mag_b = b_sgn ? -op_b : op_b;
    end

    assign div_zero = is_m && funct3[2] && (op_b == '0);
    assign div_ovf  = is_m && funct3[2] && !funct3[0] &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);

    always_comb begin
        b_eff      = sub ? ~op_b : op_b;
        sum        = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
        base_flags = {(op_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]),
                      sum[XLEN], sum[XLEN-1], (sum[XLEN-1:0] == '0)};
        base_res   = '0;
        case (funct3)
            3'b000: base_res = sum[XLEN-1:0];
            3'b001: base_res = op_a << sh;
            3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011: base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100: base_res = op_a ^ op_b;
            3'b101: begin
                // kept out of a ?: so the arithmetic shift stays signed
                if (sub) base_res = $signed(op_a) >>> sh;
                else     base_res = op_a >> sh;
            end
            3'b110: base_res = op_a | op_b;
            default: base_res = op_a & op_b;
        endcase
    end

    always_comb begin
        fa    = {a_sgn, op_a};
        fb    = {b_sgn, op_b};
        fprod = (2*XLEN)'(fa) * (2*XLEN)'(fb);
    end

    // Result captured on accept: base op, divide special case, or single-cycle product
    always_comb begin
        acc_res = base_res;
        if (is_m) begin
            if (funct3[2]) begin
                if (div_zero) acc_res = funct3[1] ? op_a : '1;
                else          acc_res = funct3[1] ? '0 : op_a;
            end else begin
                acc_res = (funct3 == 3'b000) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
            end
        end
    end

    // One shift-add multiply step or one restoring divide step on {hi,lo}
    logic [XLEN:0]     madd, rsh;
    logic              ge;
    logic [XLEN-1:0]   rdiff, step_hi, step_lo, div_pick, div_fix, fin_res;
    logic [2*XLEN-1:0] mnxt, full_fix;

    always_comb begin
        madd    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        mnxt    = {madd, lo[XLEN-1:1]};
        rsh     = {hi, lo[XLEN-1]};
        ge      = (rsh >= {1'b0, mcand});
        rdiff   = rsh[XLEN-1:0] - mcand;
        if (req.funct3[2]) begin
            step_hi = ge ? rdiff : rsh[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], ge};
        end else begin
            step_hi = mnxt[2*XLEN-1:XLEN];
            step_lo = mnxt[XLEN-1:0];
        end
        full_fix = req.neg ? -{step_hi, step_lo} : {step_hi, step_lo};
        div_pick = req.funct3[1] ? step_hi : step_lo;
        div_fix  = req.neg ? -div_pick : div_pick;
        if (req.funct3[2])              fin_res = div_fix;
        else if (req.funct3[1:0] == '0) fin_res = full_fix[XLEN-1:0];
        else                            fin_res = full_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)
                      state_nxt = (!is_m || (FAST_MUL && !funct3[2]) || div_zero || div_ovf)
                                  ? DONE : BUSY;
            BUSY: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            result    <= '0;
            alu_flags <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    req       <= '{funct3: funct3, neg: neg};
                    cnt       <= '0;
                    hi        <= '0;
                    lo        <= mag_a;
                    mcand     <= mag_b;
                    result    <= acc_res;
                    alu_flags <= is_m ? 4'b0000 : base_flags;
                end
                BUSY: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    hi  <= step_hi;
                    lo  <= step_lo;
                    if (last) result <= fin_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: stimulus pushes expectations to a queue,
// a negedge monitor pops and compares whenever out_valid rises.
module tb_seq_alu;
    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic [3:0]  alu_flags;

    seq_alu #(.XLEN(32), .FAST_MUL(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .alu_flags(alu_flags)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flg;
        bit          chk_flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          checks = 0, errors = 0, cyc = 0, mlat;
    bit          seen = 0;
    logic [31:0] hold_res;
    logic [3:0]  hold_flg;

    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_M = 7'b0000001;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: first DONE cycle is compared against the scoreboard, later DONE cycles must hold
    always @(negedge clk) begin
        if (rst || !out_valid) begin
            seen = 0;
        end else if (!seen) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: result=%h with no operation outstanding", result);
            end else begin
                me   = sb.pop_front();
                mlat = cyc - me.acc + 1;
                if (result !== me.res || (me.chk_flg && alu_flags !== me.flg) || mlat != me.lat) begin
                    errors++;
                    $display("FAIL %s: got result=%h flags=%b lat=%0d, expected result=%h flags=%b lat=%0d",
                             me.name, result, alu_flags, mlat, me.res, me.flg, me.lat);
                end
            end
            seen     = 1;
            hold_res = result;
            hold_flg = alu_flags;
        end else begin
            checks++;
            if (result !== hold_res || alu_flags !== hold_flg) begin
                errors++;
                $display("FAIL done_hold: got result=%h flags=%b, expected held result=%h flags=%b",
                         result, alu_flags, hold_res, hold_flg);
            end
        end
    end

    task automatic issue(input string nm, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                         input logic [3:0] ef, input bit cf, input int lat);
        exp_t e;
        int   t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: in_ready=%b, expected 1", nm, in_ready);
            return;
        end
        in_valid = 1; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        e.name = nm; e.res = er; e.flg = ef; e.chk_flg = cf; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        // scramble the bus so a result built from live inputs would be caught
        in_valid = 0;
        op_a = $urandom; op_b = $urandom;
        funct7 = 7'($urandom); funct3 = 3'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || in_ready !== 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d in_ready=%b, expected 0 and 1", sb.size(), in_ready);
        end
    endtask

    initial begin
        int vcnt;
        rst = 1; in_valid = 0; out_ready = 1;
        funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || alu_flags !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b result=%h flags=%b in_ready=%b, expected 0 0 0000 1",
                     out_valid, result, alu_flags, in_ready);
        end
        rst = 0;
        @(negedge clk);

        // base ops, flags {V,C,N,Z}
        issue("add_ovf",   F7_BASE, 3'b000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1010, 1, 1);
        issue("sub_zero",  F7_ALT,  3'b000, 32'd5,        32'd5,        32'h0,        4'b0101, 1, 1);
        issue("add_carry", F7_BASE, 3'b000, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0101, 1, 1);
        issue("sra",       F7_ALT,  3'b101, 32'h80000000, 32'd4,        32'hF8000000, 4'b0000, 0, 1);
        issue("srl",       F7_BASE, 3'b101, 32'h80000000, 32'd4,        32'h08000000, 4'b0000, 0, 1);
        issue("sll_mask",  F7_BASE, 3'b001, 32'h1,        32'h3F,       32'h80000000, 4'b0000, 0, 1);
        issue("slt",       F7_BASE, 3'b010, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 0, 1);
        issue("sltu",      F7_BASE, 3'b011, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0000, 0, 1);
        issue("xor",       F7_BASE, 3'b100, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A, 4'b0000, 0, 1);
        issue("or",        F7_BASE, 3'b110, 32'hF0000001, 32'h0F000010, 32'hFF000011, 4'b0000, 0, 1);
        issue("and",       F7_BASE, 3'b111, 32'hF0F0FFFF, 32'h0FF01234, 32'h00F01234, 4'b0000, 0, 1);

        // iterative multiply: XLEN+1 cycles, flags zero
        issue("mulh",      F7_M, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 1, 33);
        issue("mulhu",     F7_M, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0000, 1, 33);
        issue("mul",       F7_M, 3'b000, 32'd6,        32'd7,        32'd42,       4'b0000, 1, 33);
        issue("mul_neg",   F7_M, 3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 4'b0000, 1, 33);
        issue("mulhsu",    F7_M, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 1, 33);

        // divide, including the one-cycle special cases
        issue("div_neg",   F7_M, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0000, 1, 33);
        issue("rem_neg",   F7_M, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0000, 1, 33);
        issue("div_negb",  F7_M, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0000, 1, 33);
        issue("rem_negb",  F7_M, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        4'b0000, 1, 33);
        issue("divu",      F7_M, 3'b101, 32'd100,      32'd7,        32'd14,       4'b0000, 1, 33);
        issue("remu",      F7_M, 3'b111, 32'd100,      32'd7,        32'd2,        4'b0000, 1, 33);
        issue("divu_zero", F7_M, 3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 4'b0000, 1, 1);
        issue("remu_zero", F7_M, 3'b111, 32'd7,        32'd0,        32'd7,        4'b0000, 1, 1);
        issue("div_ovf",   F7_M, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0000, 1, 1);
        issue("rem_ovf",   F7_M, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        4'b0000, 1, 1);
        drain();

        // back-pressure: result held, new requests ignored while DONE
        out_ready = 0;
        issue("hold_add", F7_BASE, 3'b000, 32'h10, 32'h20, 32'h30, 4'b0000, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_handshake: out_valid=%b in_ready=%b, expected 1 0", out_valid, in_ready);
            end
            in_valid = 1; funct7 = F7_BASE; funct3 = 3'b000; op_a = $urandom; op_b = $urandom;
        end
        @(negedge clk);
        in_valid = 0;
        out_ready = 1;
        drain();

        // reset in the middle of an iterative divide
        in_valid = 1; funct7 = F7_M; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || alu_flags !== '0) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b result=%h flags=%b, expected 1 0 0 0000",
                     in_ready, out_valid, result, alu_flags);
        end
        @(negedge clk);
        rst = 0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abandoned_op: out_valid cycles=%0d in_ready=%b, expected 0 and 1", vcnt, in_ready);
        end
        issue("add_after_rst", F7_BASE, 3'b000, 32'd2, 32'd3, 32'd5, 4'b0000, 1, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be legal for any value 8..64.
REQ-002 Parameter FAST_MUL, default 0; 0 = iterative multiply, 1 = single-cycle multiply (BUSY skipped for MUL* ops).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 funct7  input  7  RISC-V funct7 (bit5 = sub/arith-shift, 0000001 = M-extension).
REQ-008 funct3  input  3  RISC-V funct3 operation select.
REQ-009 op_a, op_b  input  XLEN each  operands.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  operation result.
REQ-013 alu_flags  output  4  {V,C,N,Z} of the adder for base ops.

Function
REQ-014 Operation SHALL be accepted on a clk edge where in_valid && in_ready; operands and funct fields latched at that edge.
REQ-015 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE -> DONE on accept of a base op (funct7 != 0000001), a FAST_MUL=1 multiply, or a divide special case (REQ-022/023); IDLE -> BUSY on accept of any other M op.
REQ-017 BUSY SHALL run a step counter 0..XLEN-1, one multiply/divide step per cycle; BUSY -> DONE when counter = XLEN-1.
REQ-018 DONE: out_valid=1, result/alu_flags stable; DONE -> IDLE on out_ready=1; out_valid SHALL NOT drop before out_ready.
REQ-019 Latency accept -> out_valid: 1 cycle for base/fast paths, XLEN+1 cycles for iterative M ops.
REQ-020 Base ops (funct3): 000 add/sub (sub when funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when funct7[5]), 110 OR, 111 AND; shift amount = op_b[log2(XLEN)-1:0]; SLT/SLTU result zero-extended to XLEN.
REQ-021 Flags: V = signed overflow of a ± b, C = adder carry-out (for sub: 1 = no borrow), N = sum MSB, Z = sum == 0; computed for all base ops, 4'b0000 for M ops.
REQ-022 M ops (funct3): 000 MUL low XLEN, 001 MULH s×s, 010 MULHSU s×u, 011 MULHU u×u high XLEN, 100 DIV, 101 DIVU, 110 REM, 111 REMU; division truncates toward zero, remainder takes dividend sign.
REQ-023 Divide by zero SHALL give quotient all-ones and remainder = op_a, 1-cycle path.
REQ-024 DIV/REM with op_a = most-negative and op_b = -1 SHALL give quotient = op_a and remainder = 0, 1-cycle path.
REQ-025 Signed M ops SHALL convert to magnitudes before iterating and apply sign correction when entering DONE; no extra cycle.
REQ-026 in_valid while not in IDLE SHALL be ignored; operand changes after accept SHALL NOT affect the result.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter=0, out_valid=0, result=0, alu_flags=0, in_ready=1 after release.
REQ-028 Reset during BUSY or DONE SHALL abandon the operation; no out_valid for it after rst deasserts.

Verification
REQ-029 ADD 0x7FFFFFFF+1 (funct7=0, funct3=000) -> 1 cycle later result 0x80000000, flags V=1 C=0 N=1 Z=0.
REQ-030 SUB 5-5 (funct7=0100000) -> result 0, flags V=0 C=1 N=0 Z=1; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-031 MULH 0xFFFFFFFF × 0xFFFFFFFF (FAST_MUL=0) -> out_valid exactly 33 cycles after accept, result 0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000/-1 -> 0x80000000.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0, new in_valid ignored throughout.
REQ-034 rst pulsed 10 cycles into a DIVU -> out_valid=0, in_ready=1 after release; next ADD 2+3 returns 5 after 1 cycle.
